gray_conv_arbiter: RTL and testbench

Shares one binary/Gray conversion engine between NREQ requesters using round-robin arbitration and valid/ready handshakes. Each request carries an N-bit word and a mode bit selecting binary-to-Gray or Gray-to-binary. Binary-to-Gray completes in one cycle. Gray-to-binary is resolved iteratively, one bit per cycle, MSB first. Only one request is in flight at a time. The result is returned on a registered response port tagged with the requester index.

---
 rtl/gray_conv_arbiter.sv | 151 +++++++++++++++
 tb/tb_gray_conv_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary/Gray converter.
// Gray-to-binary resolves one bit per cycle, MSB first.
module gray_conv_arbiter #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [NREQ-1:0]   req_mode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  output logic              busy
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   cur_id;
  logic              found;
  logic              cur_mode;
  logic              win_mode;
  logic [NREQ-1:0]   vsh;
  logic [NREQ-1:0]   msh;
  logic [NREQ*N-1:0] dsh;
  logic [N-1:0]      win_data;
  logic [N-1:0]      g;
  logic [N-1:0]      res;
  logic [N-1:0]      res_nxt;
  logic [CW-1:0]     k;

  // Round-robin search starting just above the last grant
  always_comb begin
    found = 1'b0;
    win   = last_grant;
    cand  = '0;
    vsh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ID_W'((int'(last_grant) + 1 + i) % NREQ);
      vsh  = req_valid >> cand;
      if (!found && vsh[0]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Select the winning requester's word and mode
  always_comb begin
    dsh      = req_data >> (int'(win) * N);
    msh      = req_mode >> win;
    win_data = dsh[N-1:0];
    win_mode = msh[0];
  end

  // Next state, grant and next Gray-to-binary partial result
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    res_nxt    = res;
    res_nxt[k] = res[k + CW'(1)] ^ g[k];
    case (state)
      IDLE: begin
        if (found) begin
          req_ready = NREQ'(1) << win;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (!cur_mode || k == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, capture, conversion and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NREQ - 1);
      cur_id     <= '0;
      cur_mode   <= 1'b0;
      g          <= '0;
      res        <= '0;
      k          <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            g          <= win_data;
            cur_mode   <= win_mode;
            cur_id     <= win;
            last_grant <= win;
            res        <= {win_data[N-1], {(N-1){1'b0}}};
            k          <= CW'(N - 2);
          end
        end
        CONV: begin
          if (!cur_mode) begin
            rsp_data  <= g ^ (g >> 1);
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
          end else begin
            res <= res_nxt;
            k   <= k - CW'(1);
            if (k == '0) begin
              rsp_data  <= res_nxt;
              rsp_id    <= cur_id;
              rsp_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter.
// Expected words are hand-computed constants.
module tb_gray_conv_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_mode;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] gray_tab [16] = '{
    4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
    4'hc, 4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8
  };

  gray_conv_arbiter #(
    .N(N),
    .NREQ(NREQ),
    .ID_W(ID_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .req_mode(req_mode),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(input string tag);
    int cnt = 0;
    while (!rsp_valid && cnt < 12) begin
      tick();
      cnt++;
    end
    chk(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic xact(input int idx,
                      input logic [3:0] d,
                      input logic m,
                      output logic [3:0] q,
                      output logic [1:0] qid);
    req_data[idx*4 +: 4] = d;
    req_mode[idx]        = m;
    req_valid            = 4'(1 << idx);
    #1;
    chk("x_grant", 32'(req_ready), 32'(1 << idx));
    tick();
    req_valid = '0;
    wait_rsp("x_rsp");
    q   = rsp_data;
    qid = rsp_id;
    tick();
  endtask

  initial begin
    logic [3:0] q;
    logic [3:0] q2;
    logic [1:0] qid;
    logic [3:0] exp_rr_data [4];
    exp_rr_data = '{4'h2, 4'h4, 4'hd, 4'ha};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_mode  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();

    // binary-to-Gray from requester 0
    rsp_ready     = 1'b1;
    req_data[3:0] = 4'b1011;
    req_mode      = 4'b0000;
    req_valid     = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_nvalid", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_data", 32'(rsp_data), 32'he);
    chk("t1_id", 32'(rsp_id), 32'd0);
    chk("t1_busy_c2", 32'(busy), 32'd1);
    tick();
    chk("t1_done", 32'(rsp_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Gray-to-binary from requester 2
    req_data[11:8] = 4'b1110;
    req_mode       = 4'b0100;
    req_valid      = 4'b0100;
    #1;
    chk("t2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("t2_c1", 32'(rsp_valid), 32'd0);
    tick();
    chk("t2_c2", 32'(rsp_valid), 32'd0);
    tick();
    chk("t2_c3", 32'(rsp_valid), 32'd0);
    tick();
    chk("t2_valid", 32'(rsp_valid), 32'd1);
    chk("t2_data", 32'(rsp_data), 32'hb);
    chk("t2_id", 32'(rsp_id), 32'd2);
    tick();
    chk("t2_done", 32'(busy), 32'd0);

    // backpressure with requester 3
    req_data[15:12] = 4'b0101;
    req_mode        = 4'b0000;
    req_valid       = 4'b1000;
    #1;
    chk("bp_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    chk("bp_conv_ready", 32'(req_ready), 32'd0);
    tick();
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(rsp_data), 32'h7);
      chk("bp_hold_id", 32'(rsp_id), 32'd3);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", 32'(rsp_valid), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    // round-robin with all requesters valid
    req_data  = {4'b1111, 4'b1001, 4'b0110, 4'b0011};
    req_mode  = 4'b1010;
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 6; n++) begin
      chk("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
      tick();
      wait_rsp("rr_rsp");
      chk("rr_id", 32'(rsp_id), 32'(n % 4));
      chk("rr_data", 32'(rsp_data), 32'(exp_rr_data[n % 4]));
      tick();
      if (n == 5) begin
        req_valid = '0;
      end
    end
    tick();

    // reset during the 2nd CONV cycle of a Gray request
    req_data[15:12] = 4'b1101;
    req_mode        = 4'b1000;
    req_valid       = 4'b1000;
    #1;
    chk("rm_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_valid", 32'(rsp_valid), 32'd0);
    chk("rm_data", 32'(rsp_data), 32'd0);
    chk("rm_id", 32'(rsp_id), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("rm_first", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    wait_rsp("rm_rsp");
    tick();

    // round trip for every 4-bit value
    for (int v = 0; v < 16; v++) begin
      xact(1, 4'(v), 1'b0, q, qid);
      chk("rt_gray", 32'(q), 32'(gray_tab[v]));
      chk("rt_gid", 32'(qid), 32'd1);
      xact(3, q, 1'b1, q2, qid);
      chk("rt_bin", 32'(q2), 32'(v));
      chk("rt_bid", 32'(qid), 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
